// File: rtl/router_out_arbiter.sv
// Packet-granular round-robin arbiter: three FWFT router FIFOs onto one valid/ready egress lane.
// Optional parity checking is enabled by defining ROUTER_ARB_PARITY_CHK_EN.
module router_out_arbiter #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic [DATA_W-1:0] fifo_dout_0,
  input  logic [DATA_W-1:0] fifo_dout_1,
  input  logic [DATA_W-1:0] fifo_dout_2,
  output logic              read_enb_0,
  output logic              read_enb_1,
  output logic              read_enb_2,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              soft_reset_0,
  output logic              soft_reset_1,
  output logic              soft_reset_2,
  output logic              parity_err
);

  // state     | meaning
  // IDLE      | scanning FIFOs in round-robin order
  // SEND_HDR  | forwarding the header byte of the granted FIFO
  // SEND_BODY | forwarding payload bytes and the trailing parity byte
  typedef enum logic [1:0] {IDLE = 2'd0, SEND_HDR = 2'd1, SEND_BODY = 2'd2} state_t;

  localparam logic [7:0] STALL_MAX = 8'(TIMEOUT - 1);

  state_t            state;
  logic [1:0]        last_grant;
  logic [5:0]        cnt;
  logic [7:0]        stall;
  logic              sel_empty;
  logic [DATA_W-1:0] sel_dout;
  logic [2:0]        empty_vec;
  logic [1:0]        c0, c1, c2, win;
  logic              any_req, xfer, timeout_hit;

  assign empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign any_req   = ~&empty_vec;

  always_comb begin
    case (last_grant)
      2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
      2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
    endcase
    if (!empty_vec[c0])      win = c0;
    else if (!empty_vec[c1]) win = c1;
    else                     win = c2;
  end

  always_comb begin
    case (grant)
      2'd0:    begin sel_empty = fifo_empty_0; sel_dout = fifo_dout_0; end
      2'd1:    begin sel_empty = fifo_empty_1; sel_dout = fifo_dout_1; end
      default: begin sel_empty = fifo_empty_2; sel_dout = fifo_dout_2; end
    endcase
  end

  assign out_valid   = busy & ~sel_empty;
  assign out_data    = sel_dout;
  assign xfer        = out_valid & out_ready;
  assign timeout_hit = out_valid & ~out_ready & (stall == STALL_MAX);

  assign read_enb_0   = xfer & (grant == 2'd0);
  assign read_enb_1   = xfer & (grant == 2'd1);
  assign read_enb_2   = xfer & (grant == 2'd2);
  assign soft_reset_0 = timeout_hit & (grant == 2'd0);
  assign soft_reset_1 = timeout_hit & (grant == 2'd1);
  assign soft_reset_2 = timeout_hit & (grant == 2'd2);

  // A 63-byte payload wraps cnt to 0; modular decrement still ends after 64 body bytes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 2'd0;
      busy       <= 1'b0;
      last_grant <= 2'd2;
      cnt        <= 6'd0;
      stall      <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          stall <= 8'd0;
          if (any_req) begin
            grant <= win;
            busy  <= 1'b1;
            state <= SEND_HDR;
          end
        end
        SEND_HDR, SEND_BODY: begin
          if (xfer) begin
            stall <= 8'd0;
            if (state == SEND_HDR) begin
              cnt   <= sel_dout[7:2] + 6'd1;
              state <= SEND_BODY;
            end else begin
              cnt <= cnt - 6'd1;
              if (cnt == 6'd1) begin
                last_grant <= grant;
                busy       <= 1'b0;
                state      <= IDLE;
              end
            end
          end else if (timeout_hit) begin
            stall      <= 8'd0;
            last_grant <= grant;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (out_valid) begin
            stall <= stall + 8'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ROUTER_ARB_PARITY_CHK_EN
  logic [DATA_W-1:0] acc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)               acc <= '0;
    else if (state == IDLE)  acc <= '0;
    else if (xfer)           acc <= acc ^ out_data;
  end

  assign parity_err = xfer & (state == SEND_BODY) & (cnt == 6'd1) & (acc != out_data);
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter: behavioural FWFT FIFOs feed the DUT, expectations are hand-computed.
module tb_router_out_arbiter;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 30;
`ifdef ROUTER_ARB_PARITY_CHK_EN
  localparam logic PERR_EXP = 1'b1;
`else
  localparam logic PERR_EXP = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic [DATA_W-1:0] fifo_dout_0, fifo_dout_1, fifo_dout_2;
  logic              read_enb_0, read_enb_1, read_enb_2;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        grant;
  logic              busy;
  logic              soft_reset_0, soft_reset_1, soft_reset_2;
  logic              parity_err;

  logic [7:0] mem0[256];
  logic [7:0] mem1[256];
  logic [7:0] mem2[256];
  int wr0 = 0, wr1 = 0, wr2 = 0;
  int rd0 = 0, rd1 = 0, rd2 = 0;
  logic [7:0] pk[64];
  int np = 0;
  int b;
  int total = 0;
  int bad = 0;
  logic [2:0] re_vec, sr_vec;

  always #5 clock = ~clock;

  router_out_arbiter #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .fifo_dout_0(fifo_dout_0), .fifo_dout_1(fifo_dout_1), .fifo_dout_2(fifo_dout_2),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .grant(grant), .busy(busy),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .parity_err(parity_err)
  );

  assign fifo_empty_0 = (rd0 == wr0);
  assign fifo_empty_1 = (rd1 == wr1);
  assign fifo_empty_2 = (rd2 == wr2);
  assign fifo_dout_0  = mem0[rd0[7:0]];
  assign fifo_dout_1  = mem1[rd1[7:0]];
  assign fifo_dout_2  = mem2[rd2[7:0]];
  assign re_vec = {read_enb_2, read_enb_1, read_enb_0};
  assign sr_vec = {soft_reset_2, soft_reset_1, soft_reset_0};

  // FIFO model: pop on read_enb, flush everything on soft_reset
  always @(posedge clock) begin
    if (soft_reset_0) rd0 <= wr0; else if (read_enb_0) rd0 <= rd0 + 1;
    if (soft_reset_1) rd1 <= wr1; else if (read_enb_1) rd1 <= rd1 + 1;
    if (soft_reset_2) rd2 <= wr2; else if (read_enb_2) rd2 <= rd2 + 1;
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic put(input int f, input logic [7:0] v);
    case (f)
      0:       begin mem0[wr0[7:0]] = v; wr0++; end
      1:       begin mem1[wr1[7:0]] = v; wr1++; end
      default: begin mem2[wr2[7:0]] = v; wr2++; end
    endcase
    pk[np] = v;
    np++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks bytes pk[lo..hi-1] leave on consecutive cycles from FIFO g
  task automatic send(input int g, input int lo, input int hi, input bit fin, input logic perr);
    for (int i = lo; i < hi; i++) begin
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_data", 32'(out_data), 32'(pk[i]));
      chk("read_enb", 32'(re_vec), 32'd1 << g);
      chk("grant_hold", 32'(grant), 32'(g));
      chk("parity_err", 32'(parity_err), (fin && i == hi - 1) ? 32'(perr) : 32'd0);
      tick();
    end
    if (fin) chk("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    mem0[0] = 8'h5A;
    tick();
    tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_read_enb", 32'(re_vec), 32'd0);
    chk("rst_soft_reset", 32'(sr_vec), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h5A);
    reset = 1'b0;
    tick();

    // single packet from FIFO1
    out_ready = 1'b1;
    b = np;
    put(1, 8'h0D); put(1, 8'hA1); put(1, 8'hB2); put(1, 8'hC3); put(1, 8'hDD);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);
    tick();
    chk("single_grant", 32'(grant), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    send(1, b, b + 5, 1'b1, 1'b0);

    // round robin from reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    b = np;
    put(0, 8'h04); put(0, 8'h11); put(0, 8'h15);
    put(1, 8'h05); put(1, 8'h22); put(1, 8'h27);
    put(2, 8'h06); put(2, 8'h33); put(2, 8'h35);
    tick();
    chk("rr_grant0", 32'(grant), 32'd0);
    send(0, b, b + 3, 1'b1, 1'b0);
    tick();
    chk("rr_grant1", 32'(grant), 32'd1);
    send(1, b + 3, b + 6, 1'b1, 1'b0);
    tick();
    chk("rr_grant2", 32'(grant), 32'd2);
    send(2, b + 6, b + 9, 1'b1, 1'b0);
    b = np;
    put(0, 8'h04); put(0, 8'h77); put(0, 8'h73);
    put(1, 8'h05); put(1, 8'h01); put(1, 8'h04);
    tick();
    chk("rr_refill_grant0", 32'(grant), 32'd0);
    send(0, b, b + 3, 1'b1, 1'b0);
    tick();
    chk("rr_refill_grant1", 32'(grant), 32'd1);
    send(1, b + 3, b + 6, 1'b1, 1'b0);

    // zero-length packet
    b = np;
    put(0, 8'h00); put(0, 8'h00);
    tick();
    chk("zero_grant", 32'(grant), 32'd0);
    send(0, b, b + 2, 1'b1, 1'b0);

    // stall timeout on FIFO2 after the header
    b = np;
    put(2, 8'h0E); put(2, 8'h01); put(2, 8'h02); put(2, 8'h03); put(2, 8'h0E);
    tick();
    chk("to_grant", 32'(grant), 32'd2);
    send(2, b, b + 1, 1'b0, 1'b0);
    out_ready = 1'b0;
    #1;
    for (int i = 1; i <= TIMEOUT; i++) begin
      chk("to_soft_reset", 32'(sr_vec), (i == TIMEOUT) ? 32'd4 : 32'd0);
      chk("to_read_enb", 32'(re_vec), 32'd0);
      chk("to_busy", 32'(busy), 32'd1);
      tick();
    end
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_pulse_end", 32'(sr_vec), 32'd0);
    out_ready = 1'b1;
    b = np;
    put(0, 8'h04); put(0, 8'h9C); put(0, 8'h98);
    put(2, 8'h06); put(2, 8'h10); put(2, 8'h16);
    tick();
    chk("to_rotate_grant0", 32'(grant), 32'd0);
    send(0, b, b + 3, 1'b1, 1'b0);
    tick();
    chk("to_next_grant2", 32'(grant), 32'd2);
    send(2, b + 3, b + 6, 1'b1, 1'b0);

    // underflow wait mid-payload on FIFO0
    b = np;
    put(0, 8'h10); put(0, 8'h11); put(0, 8'h22);
    tick();
    chk("uf_grant", 32'(grant), 32'd0);
    send(0, b, b + 3, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      chk("uf_valid", 32'(out_valid), 32'd0);
      chk("uf_soft_reset", 32'(sr_vec), 32'd0);
      chk("uf_busy", 32'(busy), 32'd1);
      tick();
    end
    put(0, 8'h33); put(0, 8'h44); put(0, 8'h54);
    #1;
    send(0, b + 3, b + 6, 1'b1, 1'b0);

    // corrupted parity byte on FIFO1
    b = np;
    put(1, 8'h0D); put(1, 8'hA1); put(1, 8'hB2); put(1, 8'hC3); put(1, 8'h00);
    tick();
    chk("par_grant", 32'(grant), 32'd1);
    send(1, b, b + 5, 1'b1, PERR_EXP);
    chk("par_pulse_end", 32'(parity_err), 32'd0);

    // asynchronous reset mid-packet
    b = np;
    put(1, 8'h04); put(1, 8'h55); put(1, 8'h51);
    tick();
    chk("ar_grant", 32'(grant), 32'd1);
    send(1, b, b + 1, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_grant_rst", 32'(grant), 32'd0);
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_read_enb", 32'(re_vec), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/router_out_arbiter.md
# router_out_arbiter

Packet-granular round-robin arbiter that shares one downstream output channel among the three router output FIFOs. It selects a non-empty FIFO, forwards one complete packet (header, payload, parity) under a valid/ready handshake, then rotates priority. If the downstream stalls too long, it issues a per-FIFO soft reset. It sits between the router FIFO bank and a single-lane egress port, in place of three independent read ports.

## Interface
- `DATA_W`, default 8: byte width. Must be ≥ 8. Header layout is fixed: [7:2] payload length, [1:0] address.
- `TIMEOUT`, default 30: consecutive stalled cycles that trigger a soft reset. Range 2..255.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fifo_empty_0/1/2`  in  1 each  FIFO empty flags.
- `fifo_dout_0/1/2`  in  DATA_W each  FIFO head data. FIFOs are first-word-fall-through: dout is valid whenever the matching empty flag is low.
- `read_enb_0/1/2`  out  1 each  pops one byte from the FIFO.
- `out_data`  out  DATA_W  egress byte.
- `out_valid`  out  1  egress byte valid.
- `out_ready`  in  1  egress consumer ready.
- `grant`  out  2  index of the FIFO being served (0..2).
- `busy`  out  1  high in any state other than IDLE.
- `soft_reset_0/1/2`  out  1 each  one-cycle flush pulse to the corresponding FIFO.
- `parity_err`  out  1  one-cycle error pulse; present only with the macro defined, otherwise tied 0.

## Operation
- States: IDLE, SEND_HDR, SEND_BODY.
- Registers:
  - `last_grant` (2 bits; reset value 2, so FIFO 0 has first priority).
  - `cnt` (6 bits).
  - `stall` (8 bits).
- **IDLE**
  - Scan FIFOs in order last_grant+1, +2, +3 (mod 3); the first non-empty one wins.
  - On a win: register `grant`, go to SEND_HDR.
  - No FIFO non-empty: remain in IDLE.
- **Transfer rule** (SEND_HDR and SEND_BODY, g = grant):
  - out_valid = !fifo_empty_g.
  - out_data = fifo_dout_g.
  - read_enb_g = out_valid & out_ready; other read_enb are 0.
  - A transfer is a cycle with out_valid & out_ready.
  - When out_valid is 0, out_data is driven from the selected FIFO regardless; consumers ignore it.
- **SEND_HDR**: on transfer, cnt ← hdr[7:2] + 1 (payload plus parity byte), go to SEND_BODY. Length 0 gives cnt = 1 (parity byte only).
- **SEND_BODY**
  - Each transfer decrements cnt.
  - A transfer with cnt == 1 sends the last byte: set last_grant ← g, go to IDLE.
- **Stall counter**
  - Increments on cycles with out_valid & !out_ready.
  - Clears on any transfer and in IDLE.
  - Holds while the FIFO is empty mid-packet (an underflow wait is not a stall).
- **Timeout**
  - When stall reaches TIMEOUT-1 and the current cycle is also stalled: pulse soft_reset_g for one cycle, set last_grant ← g, clear stall, go to IDLE.
  - No read_enb is asserted in that cycle.
- **Priority rotation**: both normal completion and timeout rotate priority away from g.

## Timing
- **Reset values**:
  - Outputs: all read_enb, out_valid, busy, soft_reset_* and parity_err are 0; grant = 0; out_data = fifo_dout_0 (combinational mux at grant 0).
  - State and registers: state = IDLE, cnt = 0, stall = 0.
- **Arbitration latency**: 1 cycle. A FIFO going non-empty at edge k is granted at edge k+1; out_valid can be high from cycle k+1 onward.
- **Back-to-back packets**: one IDLE bubble cycle between consecutive packets, even from the same FIFO.
- **Throughput**: one byte per cycle while out_ready = 1 and the FIFO is non-empty. Packet of length L takes L+2 transfer cycles.
- **Combinational paths**:
  - out_valid, out_data and read_enb_g are combinational from the empty flags, dout and out_ready.
  - grant and busy are registered.
- **Timeout boundary**: stall cycles 1..TIMEOUT-1 only count. The TIMEOUT-th consecutive stall cycle has soft_reset high; the state is IDLE on the next edge.
- **out_ready rising on the timeout cycle**: that cycle is a transfer, so no soft reset occurs.
- **Asynchronous reset mid-packet**: immediate return to reset values. The partial packet is not resumed.

## Configuration
- `ROUTER_ARB_PARITY_CHK_EN`:
  - **Defined**:
    - XOR accumulator (DATA_W bits), cleared in IDLE, XORed with each transferred header and payload byte.
    - On the parity-byte transfer, parity_err pulses for one cycle if the accumulator is not equal to the parity byte.
    - Data is still forwarded unchanged.
  - **Undefined**: no accumulator; parity_err is constant 0.

## Test plan
- **Single packet**: FIFO1 holds hdr 0x0D (len 3, addr 1), 0xA1, 0xB2, 0xC3, parity 0xDD; out_ready = 1. Expected:
  - grant = 1 one cycle after not-empty;
  - 5 consecutive transfers of exactly those bytes;
  - busy falls after the 5th transfer;
  - parity_err stays 0.
- **Round robin**: all three FIFOs each hold one length-1 packet from reset. Expected:
  - grant sequence 0, 1, 2;
  - a further packet refilled in FIFO0 is granted next.
- **Zero length**: hdr 0x00 plus parity 0x00 in FIFO0. Expected: exactly 2 transfers, then IDLE.
- **Stall timeout**: TIMEOUT = 30, out_ready held 0 after the header transfer on FIFO2. Expected:
  - soft_reset_2 high exactly on the 30th stall cycle for 1 cycle;
  - no read_enb_2 in that cycle;
  - IDLE on the next edge;
  - next grant rotates to 0.
- **Underflow wait**: FIFO0 empties mid-payload for 40 cycles with out_ready = 1. Expected:
  - out_valid = 0 during the gap;
  - no soft reset;
  - transfer resumes and the packet completes.
- **Parity error (macro defined)**: parity byte corrupted to 0x00 in the single-packet case. Expected: parity_err is a 1-cycle pulse on the last transfer. With the macro undefined, parity_err stays 0.
